// File: rtl/ft_cmd_frame_engine.sv
// Length-framed command engine: parses AA|CODE|LEN|payload|55 frames from the rx FIFO,
// maintains shadow/active phase registers, LED bit and error counter, and answers ACK/NAK.
module ft_cmd_frame_engine #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_W      = 8,
  parameter int TIMEOUT_CYC  = 65536,
  parameter int ERR_W        = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rx_empty_i,
  output logic                            rx_rd_o,
  input  logic                            rx_valid_i,
  input  logic [7:0]                      rx_data_i,
  input  logic                            tx_full_i,
  output logic                            tx_wr_o,
  output logic [7:0]                      tx_data_o,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases_o,
  output logic                            phase_commit_o,
  output logic                            led_o,
  output logic [ERR_W-1:0]                err_cnt_o
);

  localparam int PB = 2 * NUM_CHANNELS;
  localparam int BL = (PB < 3) ? 3 : PB;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [15:0] C_SET    = 16'h0001;
  localparam logic [15:0] C_BULK   = 16'h0002;
  localparam logic [15:0] C_COMMIT = 16'h0003;
  localparam logic [15:0] C_LOADC  = 16'h0004;
  localparam logic [15:0] C_LED    = 16'h1ED0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_SUFFIX  = 3'd3,
    S_EXEC    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                            rx_rd_q, rx_rd_d, pend_q, pend_d;
  logic [31:0]                     hdr_q, hdr_d;
  logic [1:0]                      hdr_cnt_q, hdr_cnt_d;
  logic [15:0]                     pay_cnt_q, pay_cnt_d;
  logic [7:0]                      buf_q [BL];
  logic [7:0]                      buf_d [BL];
  logic [PHASE_W-1:0]              shadow_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]              shadow_d [NUM_CHANNELS];
  logic [NUM_CHANNELS*PHASE_W-1:0] phases_q, phases_d;
  logic                            commit_q, commit_d, led_q, led_d, nak_q, nak_d;
  logic                            tx_wr_q, tx_wr_d;
  logic [7:0]                      tx_data_q, tx_data_d;
  logic [ERR_W-1:0]                err_q, err_d;
  logic [TW-1:0]                   tmo_q, tmo_d;
  logic [15:0]                     word_s, code_s, len_s, hdr_len_s;
  logic                            byte_v_s, fetch_s, timing_s, tmo_hit_s, cmd_ok_s;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      return v;
    end else begin
      return v + ERR_W'(1);
    end
  endfunction

  // A byte only counts when it answers our own outstanding read.
  assign byte_v_s  = rx_valid_i & pend_q;
  assign code_s    = hdr_q[31:16];
  assign len_s     = hdr_q[15:0];
  assign hdr_len_s = {hdr_q[7:0], rx_data_i};
  assign fetch_s   = (state_q == S_IDLE) | timing_s;
  assign timing_s  = (state_q == S_HDR) | (state_q == S_PAYLOAD) | (state_q == S_SUFFIX);
  assign tmo_hit_s = timing_s & ~byte_v_s & (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    cmd_ok_s = 1'b0;
    case (code_s)
      C_SET:    cmd_ok_s = (len_s == 16'd3) && (buf_q[0] < 8'(NUM_CHANNELS));
      C_BULK:   cmd_ok_s = (len_s == 16'(PB));
      C_COMMIT: cmd_ok_s = (len_s == 16'd0);
      C_LOADC:  cmd_ok_s = (len_s == 16'(PB));
      C_LED:    cmd_ok_s = (len_s == 16'd1);
      default:  cmd_ok_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (byte_v_s && rx_data_i == 8'hAA) state_d = S_HDR;
        else                                state_d = S_IDLE;
      end
      S_HDR: begin
        if (tmo_hit_s)                                state_d = S_IDLE;
        else if (byte_v_s && hdr_cnt_q == 2'd3)       state_d = (hdr_len_s == 16'd0) ? S_SUFFIX : S_PAYLOAD;
        else                                          state_d = S_HDR;
      end
      S_PAYLOAD: begin
        if (tmo_hit_s)                                    state_d = S_IDLE;
        else if (byte_v_s && pay_cnt_q == len_s - 16'd1)  state_d = S_SUFFIX;
        else                                              state_d = S_PAYLOAD;
      end
      S_SUFFIX: begin
        if (tmo_hit_s)     state_d = S_IDLE;
        else if (byte_v_s) state_d = (rx_data_i == 8'h55) ? S_EXEC : S_RESP;
        else               state_d = S_SUFFIX;
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP: begin
        if (!tx_full_i) state_d = S_IDLE;
        else            state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_rd_d   = 1'b0;
    pend_d    = pend_q;
    hdr_d     = hdr_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    buf_d     = buf_q;
    shadow_d  = shadow_q;
    phases_d  = phases_q;
    commit_d  = 1'b0;
    led_d     = led_q;
    err_d     = err_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    nak_d     = nak_q;
    word_s    = 16'h0000;

    if (fetch_s && !pend_q && !rx_empty_i) begin
      rx_rd_d = 1'b1;
      pend_d  = 1'b1;
    end else if (byte_v_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (timing_s && !byte_v_s && !tmo_hit_s) tmo_d = tmo_q + TW'(1);
    else                                     tmo_d = '0;

    case (state_q)
      S_IDLE: hdr_cnt_d = 2'd0;
      S_HDR: begin
        if (tmo_hit_s) begin
          err_d = sat_inc(err_q);
        end else if (byte_v_s) begin
          hdr_d     = {hdr_q[23:0], rx_data_i};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          pay_cnt_d = 16'd0;
        end else begin
          hdr_d = hdr_q;
        end
      end
      S_PAYLOAD: begin
        if (tmo_hit_s) begin
          err_d = sat_inc(err_q);
        end else if (byte_v_s) begin
          for (int i = 0; i < BL; i++) begin
            if (pay_cnt_q == 16'(i)) buf_d[i] = rx_data_i;
            else                     buf_d[i] = buf_q[i];
          end
          pay_cnt_d = pay_cnt_q + 16'd1;
        end else begin
          pay_cnt_d = pay_cnt_q;
        end
      end
      S_SUFFIX: begin
        if (tmo_hit_s) begin
          err_d = sat_inc(err_q);
        end else if (byte_v_s && rx_data_i != 8'h55) begin
          nak_d = 1'b1;
          err_d = sat_inc(err_q);
        end else begin
          nak_d = 1'b0;
        end
      end
      S_EXEC: begin
        if (cmd_ok_s) begin
          nak_d = 1'b0;
          case (code_s)
            C_SET: begin
              word_s = {buf_q[1], buf_q[2]};
              for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (buf_q[0] == 8'(i)) shadow_d[i] = word_s[PHASE_W-1:0];
                else                   shadow_d[i] = shadow_q[i];
              end
            end
            C_BULK, C_LOADC: begin
              for (int i = 0; i < NUM_CHANNELS; i++) begin
                word_s      = {buf_q[2*i], buf_q[2*i+1]};
                shadow_d[i] = word_s[PHASE_W-1:0];
                if (code_s == C_LOADC) phases_d[i*PHASE_W +: PHASE_W] = word_s[PHASE_W-1:0];
                else                   phases_d[i*PHASE_W +: PHASE_W] = phases_q[i*PHASE_W +: PHASE_W];
              end
              commit_d = (code_s == C_LOADC);
            end
            C_COMMIT: begin
              for (int i = 0; i < NUM_CHANNELS; i++) phases_d[i*PHASE_W +: PHASE_W] = shadow_q[i];
              commit_d = 1'b1;
            end
            C_LED:   led_d = buf_q[0][0];
            default: led_d = led_q;
          endcase
        end else begin
          nak_d = 1'b1;
          err_d = sat_inc(err_q);
        end
      end
      S_RESP: begin
        if (!tx_full_i) begin
          tx_wr_d   = 1'b1;
          tx_data_d = nak_q ? 8'hEE : 8'hA5;
        end else begin
          tx_wr_d = 1'b0;
        end
      end
      default: hdr_cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_rd_q   <= 1'b0;
      pend_q    <= 1'b0;
      hdr_q     <= 32'h0;
      hdr_cnt_q <= 2'd0;
      pay_cnt_q <= 16'd0;
      for (int i = 0; i < BL; i++) buf_q[i] <= 8'h00;
      for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= '0;
      phases_q  <= '0;
      commit_q  <= 1'b0;
      led_q     <= 1'b0;
      err_q     <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      nak_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      rx_rd_q   <= rx_rd_d;
      pend_q    <= pend_d;
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      buf_q     <= buf_d;
      shadow_q  <= shadow_d;
      phases_q  <= phases_d;
      commit_q  <= commit_d;
      led_q     <= led_d;
      err_q     <= err_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      nak_q     <= nak_d;
      tmo_q     <= tmo_d;
    end
  end

  assign rx_rd_o        = rx_rd_q;
  assign tx_wr_o        = tx_wr_q;
  assign tx_data_o      = tx_data_q;
  assign phases_o       = phases_q;
  assign phase_commit_o = commit_q;
  assign led_o          = led_q;
  assign err_cnt_o      = err_q;

endmodule

// File: tb/tb_ft_cmd_frame_engine.sv
// Directed bench for ft_cmd_frame_engine: rx FIFO model feeds frames, tx/commit monitor counts responses.
module tb_ft_cmd_frame_engine;
  localparam int NC  = 4;
  localparam int PW  = 8;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_empty_i, rx_rd_o, rx_valid_i, tx_full_i, tx_wr_o;
  logic [7:0]    rx_data_i, tx_data_o;
  logic [NC*PW-1:0] phases_o;
  logic          phase_commit_o, led_o;
  logic [15:0]   err_cnt_o;

  int passed = 0;
  int total  = 0;
  int tx_cnt = 0;
  int commit_cnt = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] rx_q [$];
  int rx_lat = 1;
  int wait_cnt = 0;
  logic [7:0] rd_byte = 8'h00;

  ft_cmd_frame_engine #(.NUM_CHANNELS(NC), .PHASE_W(PW), .TIMEOUT_CYC(TMO), .ERR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .rx_empty_i(rx_empty_i), .rx_rd_o(rx_rd_o),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .tx_full_i(tx_full_i),
    .tx_wr_o(tx_wr_o), .tx_data_o(tx_data_o), .phases_o(phases_o),
    .phase_commit_o(phase_commit_o), .led_o(led_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // rx FIFO model: a read returns its byte rx_lat cycles later
  always @(posedge clk) begin
    if (rx_rd_o && rx_q.size() > 0) begin
      rd_byte  <= rx_q.pop_front();
      wait_cnt <= rx_lat;
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end
    rx_valid_i <= (wait_cnt == 1);
    rx_data_i  <= rd_byte;
  end

  always @(negedge clk) begin
    rx_empty_i = (rx_q.size() == 0);
    if (tx_wr_o) begin
      tx_cnt++;
      tx_last = tx_data_o;
    end
    if (phase_commit_o) commit_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] code, input logic [15:0] len,
                            input logic [7:0] pl [8], input int n, input logic [7:0] sfx);
    rx_q.push_back(8'hAA);
    rx_q.push_back(code[15:8]);
    rx_q.push_back(code[7:0]);
    rx_q.push_back(len[15:8]);
    rx_q.push_back(len[7:0]);
    for (int i = 0; i < n; i++) rx_q.push_back(pl[i]);
    rx_q.push_back(sfx);
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 400 && tx_cnt < target; i++) cyc(1);
    cyc(4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    total++; if ({rx_rd_o, tx_wr_o, phase_commit_o, led_o} !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", {rx_rd_o, tx_wr_o, phase_commit_o, led_o}); else passed++;
    total++; if (phases_o !== 32'h0) $display("FAIL reset_phases: got %h want 00000000", phases_o); else passed++;
    total++; if ({tx_data_o, err_cnt_o} !== 24'h0) $display("FAIL reset_txdata_err: got %h want 000000", {tx_data_o, err_cnt_o}); else passed++;
  endtask

  task automatic test_bulk_then_commit;
    send_frame(16'h0002, 16'h0008, '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44}, 8, 8'h55);
    wait_tx(1);
    total++; if (tx_cnt !== 1 || tx_last !== 8'hA5) $display("FAIL bulk_ack: got cnt %0d byte %h want 1 A5", tx_cnt, tx_last); else passed++;
    total++; if (phases_o !== 32'h0 || commit_cnt !== 0) $display("FAIL bulk_no_commit: got %h/%0d want 0/0", phases_o, commit_cnt); else passed++;
    send_frame(16'h0003, 16'h0000, '{8{8'h00}}, 0, 8'h55);
    wait_tx(2);
    total++; if (tx_cnt !== 2 || tx_last !== 8'hA5) $display("FAIL commit_ack: got cnt %0d byte %h want 2 A5", tx_cnt, tx_last); else passed++;
    total++; if (phases_o !== 32'h44332211) $display("FAIL commit_phases: got %h want 44332211", phases_o); else passed++;
    total++; if (commit_cnt !== 1) $display("FAIL commit_pulse: got %0d want 1", commit_cnt); else passed++;
  endtask

  task automatic test_set_phase;
    send_frame(16'h0001, 16'h0003, '{8'h07, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h55);
    wait_tx(3);
    total++; if (tx_last !== 8'hEE || err_cnt_o !== 16'd1) $display("FAIL set_bad_idx: got %h err %0d want EE 1", tx_last, err_cnt_o); else passed++;
    send_frame(16'h0001, 16'h0003, '{8'h02, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h55);
    send_frame(16'h0003, 16'h0000, '{8{8'h00}}, 0, 8'h55);
    wait_tx(5);
    total++; if (tx_cnt !== 5 || tx_last !== 8'hA5) $display("FAIL set_ok_ack: got cnt %0d byte %h want 5 A5", tx_cnt, tx_last); else passed++;
    total++; if (phases_o !== 32'h445A2211) $display("FAIL set_then_commit: got %h want 445A2211", phases_o); else passed++;
  endtask

  task automatic test_load_commit_and_naks;
    send_frame(16'h0004, 16'h0008, '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04}, 8, 8'h55);
    wait_tx(6);
    total++; if (phases_o !== 32'h04030201 || commit_cnt !== 3) $display("FAIL load_commit: got %h/%0d want 04030201/3", phases_o, commit_cnt); else passed++;
    send_frame(16'h0002, 16'h0002, '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h55);
    send_frame(16'h0009, 16'h0000, '{8{8'h00}}, 0, 8'h55);
    wait_tx(8);
    total++; if (tx_last !== 8'hEE || err_cnt_o !== 16'd3) $display("FAIL badlen_badcode_nak: got %h err %0d want EE 3", tx_last, err_cnt_o); else passed++;
    total++; if (phases_o !== 32'h04030201) $display("FAIL nak_no_change: got %h want 04030201", phases_o); else passed++;
  endtask

  task automatic test_led;
    send_frame(16'h1ED0, 16'h0001, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h66);
    wait_tx(9);
    total++; if (tx_last !== 8'hEE || led_o !== 1'b0 || err_cnt_o !== 16'd4) $display("FAIL led_bad_suffix: got %h led %b err %0d want EE 0 4", tx_last, led_o, err_cnt_o); else passed++;
    send_frame(16'h1ED0, 16'h0001, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h55);
    wait_tx(10);
    total++; if (tx_last !== 8'hA5 || led_o !== 1'b1) $display("FAIL led_on: got %h led %b want A5 1", tx_last, led_o); else passed++;
  endtask

  task automatic test_timeout;
    rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'h13);
    rx_q.push_back(8'hAA); rx_q.push_back(8'h00);
    cyc(40);
    total++; if (err_cnt_o !== 16'd4 || tx_cnt !== 10) $display("FAIL noise_no_err: got err %0d tx %0d want 4 10", err_cnt_o, tx_cnt); else passed++;
    cyc(60);
    total++; if (err_cnt_o !== 16'd5 || tx_cnt !== 10) $display("FAIL timeout_err: got err %0d tx %0d want 5 10", err_cnt_o, tx_cnt); else passed++;
    send_frame(16'h1ED0, 16'h0001, '{8{8'h00}}, 1, 8'h55);
    wait_tx(11);
    total++; if (tx_last !== 8'hA5 || led_o !== 1'b0) $display("FAIL after_timeout: got %h led %b want A5 0", tx_last, led_o); else passed++;
  endtask

  task automatic test_back_to_back;
    send_frame(16'h1ED0, 16'h0001, '{8{8'h00}}, 1, 8'h55);
    send_frame(16'h1ED0, 16'h0001, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h55);
    wait_tx(13);
    total++; if (tx_cnt !== 13 || tx_last !== 8'hA5 || led_o !== 1'b1) $display("FAIL back_to_back: got cnt %0d %h led %b want 13 A5 1", tx_cnt, tx_last, led_o); else passed++;
  endtask

  task automatic test_tx_full;
    tx_full_i = 1'b1;
    send_frame(16'h1ED0, 16'h0001, '{8{8'h00}}, 1, 8'h55);
    cyc(50);
    total++; if (tx_cnt !== 13 || led_o !== 1'b0) $display("FAIL tx_full_hold: got cnt %0d led %b want 13 0", tx_cnt, led_o); else passed++;
    tx_full_i = 1'b0;
    wait_tx(14);
    cyc(10);
    total++; if (tx_cnt !== 14 || tx_last !== 8'hA5) $display("FAIL tx_full_release: got cnt %0d %h want 14 A5", tx_cnt, tx_last); else passed++;
  endtask

  task automatic test_rst_mid_payload;
    bit seen;
    rx_q.push_back(8'hAA); rx_q.push_back(8'h00); rx_q.push_back(8'h04);
    rx_q.push_back(8'h00); rx_q.push_back(8'h08); rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    cyc(30);
    rx_lat = 8;
    rx_q.push_back(8'hAA);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (rx_rd_o) seen = 1'b1;
      else cyc(1);
    end
    total++; if (seen !== 1'b1) $display("FAIL rst_read_issued: got %b want 1", seen); else passed++;
    rst = 1'b1;
    cyc(2);
    total++; if ({phases_o, led_o, err_cnt_o, tx_data_o, tx_wr_o, rx_rd_o, phase_commit_o} !== 59'h0) $display("FAIL rst_mid_outputs: got %h %b %0d %h want all zero", phases_o, led_o, err_cnt_o, tx_data_o); else passed++;
    rst = 1'b0;
    cyc(12);
    rx_lat = 1;
    send_frame(16'h1ED0, 16'h0001, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h55);
    wait_tx(15);
    total++; if (tx_cnt !== 15 || tx_last !== 8'hA5 || led_o !== 1'b1 || err_cnt_o !== 16'd0) $display("FAIL late_valid_ignored: got cnt %0d %h led %b err %0d want 15 A5 1 0", tx_cnt, tx_last, led_o, err_cnt_o); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    tx_full_i = 1'b0;
    rx_empty_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    test_reset;
    test_bulk_then_commit;
    test_set_phase;
    test_load_commit_and_naks;
    test_led;
    test_timeout;
    test_back_to_back;
    test_tx_full;
    test_rst_mid_payload;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
